// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Pipeline register between instruction decode and execute. Each cycle it
// latches the decoded control bits and operands of the instruction in ID.
// It also detects load-use hazards, stalls the front end, and inserts bubbles
// when a hazard or a branch/jump flush occurs. A HALT that reaches EX freezes
// the stage until reset.
//
// Optional build feature (macro ID_EX_PERF_CNT_EN):
//   When defined, the output bubble_cnt is added. It is a saturating count of
//   the bubbles inserted because of a flush or a load-use hazard.
//
// Flow control:
//   id_valid marks a real instruction in ID. When this stage asserts
//   hazard_stall, the front end must hold PC and IF/ID, then present the same
//   instruction again on the next cycle. While ex_stall is high, this stage
//   holds every register and consumes nothing. A flush that coincides with
//   ex_stall must stay asserted until ex_stall drops.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   id_*              decoded instruction fields presented by ID
//   id_valid          ID holds a real instruction
//   ex_stall          downstream hold
//   flush             kill the instruction currently in ID
//   ex_*              registered copies of id_*, plus ex_valid
//   hazard_stall      combinational load-use stall toward PC and IF/ID
//   halted            sticky HALT indicator
//   bubble_cnt        (ID_EX_PERF_CNT_EN only) saturating bubble counter
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_memtoreg,
    input  logic              id_memwrite,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic              id_regwrite,
    input  logic              id_branch,
    input  logic              id_jump,
    input  logic              id_halt,
    input  logic [5:0]        id_alucontrol,
    input  logic [2:0]        id_memop,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              ex_stall,
    input  logic              flush,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       bubble_cnt,
`endif
    output logic              hazard_stall,
    output logic              halted,
    output logic              ex_valid,
    output logic              ex_memtoreg,
    output logic              ex_memwrite,
    output logic              ex_alusrc,
    output logic              ex_regdst,
    output logic              ex_regwrite,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic              ex_halt,
    output logic [5:0]        ex_alucontrol,
    output logic [2:0]        ex_memop,
    output logic              ex_uses_rt,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd
);

    typedef struct packed {
        logic              valid;
        logic              memtoreg;
        logic              memwrite;
        logic              alusrc;
        logic              regdst;
        logic              regwrite;
        logic              branch;
        logic              jump;
        logic              halt;
        logic [5:0]        alucontrol;
        logic [2:0]        memop;
        logic              uses_rt;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } stage_t;

    stage_t id_word;
    stage_t ex_q;
    logic   load_in_ex;
    logic   rt_match;
    logic   load_bubble;

    assign id_word.valid      = id_valid;
    assign id_word.memtoreg   = id_memtoreg;
    assign id_word.memwrite   = id_memwrite;
    assign id_word.alusrc     = id_alusrc;
    assign id_word.regdst     = id_regdst;
    assign id_word.regwrite   = id_regwrite;
    assign id_word.branch     = id_branch;
    assign id_word.jump       = id_jump;
    assign id_word.halt       = id_halt;
    assign id_word.alucontrol = id_alucontrol;
    assign id_word.memop      = id_memop;
    assign id_word.uses_rt    = id_uses_rt;
    assign id_word.pc4        = id_pc4;
    assign id_word.rd1        = id_rd1;
    assign id_word.rd2        = id_rd2;
    assign id_word.imm        = id_imm;
    assign id_word.rs         = id_rs;
    assign id_word.rt         = id_rt;
    assign id_word.rd         = id_rd;

    // A real load writes a register from memory. LUI also sets memtoreg, but
    // it has memop == 000, so the memop term excludes it.
    assign load_in_ex = ex_q.valid & ex_q.memtoreg & ex_q.regwrite & (ex_q.memop != 3'b000);

    // rt is compared only for instructions that actually read it. Writes to
    // $0 never create a dependency. A flush already kills ID, so it suppresses
    // the stall.
    assign rt_match = (ex_q.rt == id_rs) | (id_uses_rt & (ex_q.rt == id_rt));
    assign hazard_stall = ~halted & load_in_ex & (ex_q.rt != '0) & id_valid & ~flush & rt_match;

    // Bubbles that the counter records. Idle slots where id_valid is low are
    // not counted.
    assign load_bubble = ~halted & ~ex_stall & (flush | hazard_stall);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q   <= '0;
            halted <= 1'b0;
        end else if (!halted && !ex_stall) begin
            if (flush || hazard_stall || !id_valid) begin
                ex_q <= '0;
            end else begin
                ex_q   <= id_word;
                halted <= id_halt;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (load_bubble && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`else
    logic unused_bubble;
    assign unused_bubble = load_bubble;
`endif

    assign ex_valid      = ex_q.valid;
    assign ex_memtoreg   = ex_q.memtoreg;
    assign ex_memwrite   = ex_q.memwrite;
    assign ex_alusrc     = ex_q.alusrc;
    assign ex_regdst     = ex_q.regdst;
    assign ex_regwrite   = ex_q.regwrite;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
    assign ex_halt       = ex_q.halt;
    assign ex_alucontrol = ex_q.alucontrol;
    assign ex_memop      = ex_q.memop;
    assign ex_uses_rt    = ex_q.uses_rt;
    assign ex_pc4        = ex_q.pc4;
    assign ex_rd1        = ex_q.rd1;
    assign ex_rd2        = ex_q.rd2;
    assign ex_imm        = ex_q.imm;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Testbench for id_ex_stage. A behavioural model tracks the instruction that
// should sit in EX, the halt flag and the bubble count. A negedge process
// compares the DUT with the model on every cycle. A set of directed scenarios
// pins the model against hand-computed values. Between them, a randomized
// phase acts as the front end and holds ID whenever a stall is expected.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int RW = 5;

    typedef struct packed {
        logic          valid;
        logic          memtoreg;
        logic          memwrite;
        logic          alusrc;
        logic          regdst;
        logic          regwrite;
        logic          branch;
        logic          jump;
        logic          halt;
        logic [5:0]    alucontrol;
        logic [2:0]    memop;
        logic          uses_rt;
        logic [DW-1:0] pc4;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
    } instr_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instr_t id = '0;
    logic   ex_stall = 1'b0;
    logic   flush = 1'b0;

    logic          hazard_stall, halted;
    logic          ex_valid, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regdst;
    logic          ex_regwrite, ex_branch, ex_jump, ex_halt, ex_uses_rt;
    logic [5:0]    ex_alucontrol;
    logic [2:0]    ex_memop;
    logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]   bubble_cnt;
`endif

    instr_t act;
    assign act = {ex_valid, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regdst,
                  ex_regwrite, ex_branch, ex_jump, ex_halt, ex_alucontrol,
                  ex_memop, ex_uses_rt, ex_pc4, ex_rd1, ex_rd2, ex_imm,
                  ex_rs, ex_rt, ex_rd};

    id_ex_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id.valid), .id_memtoreg(id.memtoreg), .id_memwrite(id.memwrite),
        .id_alusrc(id.alusrc), .id_regdst(id.regdst), .id_regwrite(id.regwrite),
        .id_branch(id.branch), .id_jump(id.jump), .id_halt(id.halt),
        .id_alucontrol(id.alucontrol), .id_memop(id.memop), .id_uses_rt(id.uses_rt),
        .id_pc4(id.pc4), .id_rd1(id.rd1), .id_rd2(id.rd2), .id_imm(id.imm),
        .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
        .ex_stall(ex_stall), .flush(flush),
`ifdef ID_EX_PERF_CNT_EN
        .bubble_cnt(bubble_cnt),
`endif
        .hazard_stall(hazard_stall), .halted(halted),
        .ex_valid(ex_valid), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
        .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_regwrite(ex_regwrite),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_halt(ex_halt),
        .ex_alucontrol(ex_alucontrol), .ex_memop(ex_memop), .ex_uses_rt(ex_uses_rt),
        .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    instr_t      m_ex = '0;
    logic        m_halted = 1'b0;
    logic [31:0] m_cnt = '0;
    bit          chk_en = 1'b0;

    // The instruction in EX is a real memory load.
    function automatic logic m_is_load();
        return m_ex.valid && m_ex.memtoreg && m_ex.regwrite && (m_ex.memop != 3'b000);
    endfunction

    // ID reads the register that the load in EX will write.
    function automatic logic exp_haz();
        logic dep;
        if (m_halted) return 1'b0;
        dep = (m_ex.rt == id.rs) || (id.uses_rt && (m_ex.rt == id.rt));
        return m_is_load() && (m_ex.rt != 0) && id.valid && !flush && dep;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ex = '0;
            m_halted = 1'b0;
            m_cnt = '0;
        end else if (!m_halted && !ex_stall) begin
            if (flush || exp_haz()) begin
                m_ex = '0;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end else if (id.valid) begin
                m_ex = id;
                if (id.halt) m_halted = 1'b1;
            end else begin
                m_ex = '0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_hazard", hazard_stall, exp_haz());
            check("cyc_ex", act, m_ex);
            check("cyc_halted", halted, m_halted);
`ifdef ID_EX_PERF_CNT_EN
            check("cyc_bubble_cnt", bubble_cnt, m_cnt);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t rand_instr();
        instr_t r;
        int kind;
        r = '0;
        r.valid      = ($urandom_range(0, 7) != 0);
        r.alucontrol = 6'($urandom_range(0, 63));
        r.alusrc     = 1'($urandom_range(0, 1));
        r.pc4        = $urandom;
        r.rd1        = $urandom;
        r.rd2        = $urandom;
        r.imm        = $urandom;
        r.rs         = 5'($urandom_range(0, 3));
        r.rt         = 5'($urandom_range(0, 3));
        r.rd         = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) r.rs = 5'($urandom_range(0, 31));
        kind = $urandom_range(0, 3);
        case (kind)
            0: begin
                r.memtoreg = 1'b1;
                r.regwrite = 1'b1;
                case ($urandom_range(0, 2))
                    0: r.memop = 3'b001;
                    1: r.memop = 3'b010;
                    default: r.memop = 3'b100;
                endcase
            end
            1: begin
                r.memtoreg = 1'b1;
                r.regwrite = 1'b1;
            end
            2: begin
                r.regwrite = 1'b1;
                r.regdst   = 1'b1;
                r.uses_rt  = 1'b1;
            end
            default: begin
                r.memwrite = 1'($urandom_range(0, 1));
                r.branch   = ~r.memwrite;
                r.jump     = 1'($urandom_range(0, 1)) & ~r.memwrite;
                r.uses_rt  = 1'b1;
                r.memop    = r.memwrite ? 3'b100 : 3'b000;
            end
        endcase
        return r;
    endfunction

    task automatic drive_lw(input logic [RW-1:0] rt);
        id = '0;
        id.valid = 1'b1; id.memtoreg = 1'b1; id.regwrite = 1'b1; id.alusrc = 1'b1;
        id.memop = 3'b100; id.alucontrol = 6'b100000; id.rs = 5'd3; id.rt = rt; id.imm = 32'd16;
    endtask

    task automatic drive_add(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
        id = '0;
        id.valid = 1'b1; id.regwrite = 1'b1; id.regdst = 1'b1; id.uses_rt = 1'b1;
        id.alucontrol = 6'b100000; id.rs = rs; id.rt = rt; id.rd = 5'd10;
    endtask

    // ---------------- stimulus ----------------
    logic hold;
    logic keep_flush;

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_ex", act, '0);
        check("rst_halted", halted, 0);
        reset = 1'b0;

        // Put a nonzero instruction into EX, then assert reset mid-cycle
        // while every input is nonzero.
        id = rand_instr();
        id.valid = 1'b1;
        id.halt = 1'b0;
        id.pc4 = 32'h1234;
        tick();
        check("pre_rst_pc4", ex_pc4, 32'h1234);
        id = '1;
        ex_stall = 1'b1;
        flush = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_rst_ex", act, '0);
        check("async_rst_halted", halted, 0);
        tick();
        reset = 1'b0;
        id = '0;
        ex_stall = 1'b0;
        flush = 1'b0;

        // Load an addi. It shows up on EX one edge later.
        id.valid = 1'b1; id.alucontrol = 6'b100000; id.regwrite = 1'b1; id.alusrc = 1'b1;
        id.imm = 32'd5; id.rs = 5'd1; id.rt = 5'd2; id.pc4 = 32'h4;
        tick();
        check("addi_valid", ex_valid, 1);
        check("addi_alu", ex_alucontrol, 6'b100000);
        check("addi_imm", ex_imm, 32'd5);
        check("addi_regwrite", ex_regwrite, 1);

        // Load-use: lw $8, then add reading $8.
        drive_lw(5'd8);
        tick();
        drive_add(5'd8, 5'd9);
        #1 check("lu_stall", hazard_stall, 1);
        tick();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_regwrite", ex_regwrite, 0);
        check("lu_stall_released", hazard_stall, 0);
        tick();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_rs", ex_rs, 5'd8);
        check("lu_add_rd", ex_rd, 5'd10);
`ifdef ID_EX_PERF_CNT_EN
        check("lu_bubble_cnt", bubble_cnt, 1);
`endif

        // LUI to $8 followed by a use of $8 does not stall.
        id = '0;
        id.valid = 1'b1; id.memtoreg = 1'b1; id.regwrite = 1'b1; id.alusrc = 1'b1; id.rt = 5'd8;
        tick();
        drive_add(5'd8, 5'd8);
        #1 check("lui_no_stall", hazard_stall, 0);
        tick();

        // A load to $0 followed by a use of $0 does not stall.
        drive_lw(5'd0);
        tick();
        drive_add(5'd0, 5'd0);
        #1 check("r0_no_stall", hazard_stall, 0);
        tick();

        // A flush wins over a load-use hazard.
        drive_lw(5'd8);
        tick();
        drive_add(5'd8, 5'd1);
        flush = 1'b1;
        #1 check("flush_no_stall", hazard_stall, 0);
        tick();
        check("flush_bubble", ex_valid, 0);
        flush = 1'b0;

        // ex_stall holds EX for 3 cycles, even with flush high.
        id = '0;
        id.valid = 1'b1; id.regwrite = 1'b1; id.imm = 32'h77; id.rd1 = 32'hAAAA;
        tick();
        check("hold_loaded", ex_imm, 32'h77);
        ex_stall = 1'b1;
        flush = 1'b1;
        id = rand_instr();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_imm", ex_imm, 32'h77);
            check("hold_rd1", ex_rd1, 32'hAAAA);
            check("hold_valid", ex_valid, 1);
        end
        ex_stall = 1'b0;
        tick();
        check("hold_release_bubble", ex_valid, 0);
        check("hold_release_imm", ex_imm, 0);
        flush = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
        check("cnt_after_directed", bubble_cnt, 3);
`endif

        // Randomized phase. The bench behaves as a well-formed front end.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            hold = exp_haz() || ex_stall;
            keep_flush = ex_stall && flush;
            @(posedge clk);
            #1;
            if (!hold) id = rand_instr();
            ex_stall = ($urandom_range(0, 9) < 2);
            flush = keep_flush ? 1'b1 : ($urandom_range(0, 9) == 0);
        end
        ex_stall = 1'b0;
        flush = 1'b0;
        id = '0;
        tick();

        // HALT is sticky. Later changes to ID are ignored.
        id.valid = 1'b1; id.halt = 1'b1; id.pc4 = 32'h100;
        tick();
        check("halt_halted", halted, 1);
        check("halt_ex_halt", ex_halt, 1);
        check("halt_ex_valid", ex_valid, 1);
        for (int i = 0; i < 10; i++) begin
            id = rand_instr();
            flush = 1'($urandom_range(0, 1));
            ex_stall = 1'($urandom_range(0, 1));
            tick();
            check("halt_hold_pc4", ex_pc4, 32'h100);
            check("halt_hold_halted", halted, 1);
            check("halt_no_stall", hazard_stall, 0);
        end
        #2 reset = 1'b1;
        #1;
        check("halt_reset_halted", halted, 0);
        check("halt_reset_ex", act, '0);
        tick();
        reset = 1'b0;
        id = '0;
        flush = 1'b0;
        ex_stall = 1'b0;
        repeat (3) tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound on the run.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode (decoder + register file + immediate extension) and the execute stage.
- Latches decoded control bits and operands every cycle.
- Detects load-use hazards, generates the upstream stall, and inserts bubbles on hazard or branch flush.
- Makes HALT sticky: once a HALT instruction reaches EX, the pipeline front end freezes.

Parameters:
- DATA_W, 32, operand and PC width.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_memtoreg, id_memwrite, id_alusrc, id_regdst, id_regwrite, id_branch, id_jump, id_halt  in  1 each  decoded control bits.
- id_alucontrol  in  6  ALU function code.
- id_memop  in  3  memory access size (001 byte, 010 half, 100 word, 000 none).
- id_uses_rt  in  1  instruction reads rt as a source (R-type, branches, stores).
- id_pc4, id_rd1, id_rd2, id_imm  in  DATA_W each  PC+4, register reads, extended immediate.
- id_rs, id_rt, id_rd  in  REG_W each  register indices.
- ex_stall  in  1  downstream hold (multi-cycle memory/ALU).
- flush  in  1  branch/jump taken; kill the instruction currently in ID.
- hazard_stall  out  1  combinational; freezes PC and IF/ID.
- halted  out  1  sticky halt indicator.
- ex_* outputs  out  widths as the id_* inputs  registered copies, plus ex_valid.

Behaviour:
- Reset: asynchronous; takes effect immediately on assertion regardless of clk.
  - Every ex_* output goes to 0, ex_valid=0, halted=0.
  - A bubble is all-zero: RegWrite=0, MemWrite=0, Branch=0, Jump=0, MemOp=000, ALUControl=000000.
- Load detection: ex_valid & ex_memtoreg & ex_regwrite & (ex_memop!=000).
  - The MemOp term excludes LUI, which drives MemtoReg=1 with MemOp=000.
- hazard_stall = load & (ex_rt!=0) & id_valid & ~flush & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Per-edge priority, highest first:
  1. halted=1: hold all registers; hazard_stall forced 0.
  2. ex_stall=1: hold all registers, including during a flush. The flush source must keep flush asserted until ex_stall drops.
  3. flush=1: load a bubble.
  4. hazard_stall=1: load a bubble. ID contents are held upstream and re-presented next cycle, giving exactly 1 bubble per load-use.
  5. Otherwise: load the id_* values; ex_valid=id_valid. If id_valid=0, load a bubble.
- Latency: 1 cycle from ID to EX outputs. Throughput: 1 instruction/cycle absent stalls.
- Halt:
  - When an instruction with id_halt=1 is loaded, halted rises on the same edge.
  - The HALT fields remain on the ex_* outputs; ex_valid stays 1.
  - Cleared only by reset.
- No register-index wrap or arithmetic; the block contains comparisons only.
- Reset asserted mid-stall or mid-halt: all state returns to the reset values above; no pending bubble survives.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds output bubble_cnt, 32 bits.
  - Increments on every edge that loads a bubble due to hazard_stall or flush while halted=0 and ex_stall=0.
  - Saturates at 0xFFFFFFFF; resets to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: assert reset mid-cycle with all inputs nonzero -> outputs 0 immediately; release; `addi` (alucontrol 100000, regwrite=1, imm=5) -> appears on ex_* one edge later with ex_valid=1.
- Load-use: `lw` to rt=8, then `add` with rs=8 -> hazard_stall=1 for 1 cycle; EX shows a bubble; `add` enters EX next edge; bubble_cnt=1 if ID_EX_PERF_CNT_EN.
- LUI and $0: `lui` to rt=8 then `add` rs=8 -> hazard_stall stays 0; `lw` to rt=0 then a use of $0 -> no stall.
- Flush vs hazard: flush=1 in the same cycle as a load-use condition -> hazard_stall=0, bubble loaded, ex_valid=0.
- ex_stall: hold 3 cycles with flush=1 -> ex_* unchanged throughout; after release with flush still 1 -> bubble.
- Halt: id_halt=1 loaded -> halted=1 on that edge; later id_* changes ignored for 10 cycles; reset clears halted.
